// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM/WB stage and the hazard unit:
// opcodes, memory-access FSM encoding and the write-back bundle layout.
package mem_wb_stage_pkg;

    localparam logic [5:0] OP_OPERATION = 6'b000000;
    localparam logic [5:0] OP_LW        = 6'b100011;
    localparam logic [5:0] OP_SW        = 6'b101011;
    localparam logic [5:0] OP_BNE       = 6'b000101;
    localparam logic [5:0] OP_J         = 6'b000010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [31:0] ir;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
    } wb_t;

    function automatic logic is_mem(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_wb_stage_dmem_handshake.sv
// Data-memory request/ready handshake: access FSM, request registers,
// saturating timeout counter and load buffer.
module dmem_handshake
    import mem_wb_stage_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        timeout
);

    localparam int CLOG = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW   = (CLOG > 8) ? CLOG : 8;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    mem_state_t    state;
    logic [CW-1:0] cnt;

    assign busy = (state == ST_BUSY);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            cnt        <= '0;
            rdata      <= '0;
            timeout    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_BUSY;
                        dmem_req   <= 1'b1;
                        dmem_we    <= we;
                        dmem_addr  <= addr;
                        dmem_wdata <= wdata;
                        cnt        <= '0;
                    end
                end
                ST_BUSY: begin
                    // ready on the final counted cycle still takes real data
                    if (dmem_ready) begin
                        rdata    <= dmem_rdata;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        state    <= ST_DONE;
                    end else if (cnt == LAST) begin
                        rdata    <= ERR_DATA;
                        timeout  <= 1'b1;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        state    <= ST_DONE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB pipeline register: issues LW/SW to
// data memory, stalls upstream while busy, registers the WB bundle.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    input  logic [31:0] alureg_input,
    input  logic [31:0] ir_input,
    input  logic [31:0] pc_input,
    input  logic [31:0] store_data_input,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [31:0] wb_ir,
    output logic [31:0] wb_pc,
    output logic        rf_write_enable,
    output logic [4:0]  rf_waddr,
    output logic        align_error,
    output logic        dmem_timeout
);

    logic [5:0]  op;
    logic        mem_op;
    logic        misaligned;
    logic        start;
    logic        busy;
    logic        done;
    logic        idle;
    logic        retire;
    logic [31:0] rdata;
    logic [31:0] lat_ir;
    logic [31:0] lat_pc;
    logic [31:0] lat_alu;
    wb_t         wb;

    assign op         = ir_input[31:26];
    assign mem_op     = is_mem(op);
    assign misaligned = (alureg_input[1:0] != 2'b00);
    assign idle       = !busy && !done;
    assign start      = idle && in_valid && mem_op && !misaligned;
    assign retire     = idle && in_valid && !start;
    assign stall      = start || busy;

    dmem_handshake #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .ERR_DATA      (ERR_DATA)
    ) u_hs (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .we        (op == OP_SW),
        .addr      ({alureg_input[31:2], 2'b00}),
        .wdata     (store_data_input),
        .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .timeout   (dmem_timeout)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lat_ir  <= '0;
            lat_pc  <= '0;
            lat_alu <= '0;
        end else if (start) begin
            lat_ir  <= ir_input;
            lat_pc  <= pc_input;
            lat_alu <= alureg_input;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb          <= '0;
            align_error <= 1'b0;
        end else begin
            wb.valid <= 1'b0;
            wb.we    <= 1'b0;
            unique case (1'b1)
                done: begin
                    wb.valid <= 1'b1;
                    wb.ir    <= lat_ir;
                    wb.pc    <= lat_pc;
                    if (lat_ir[31:26] == OP_LW) begin
                        wb.data  <= rdata;
                        wb.we    <= 1'b1;
                        wb.waddr <= lat_ir[20:16];
                    end else begin
                        wb.data  <= lat_alu;
                        wb.waddr <= '0;
                    end
                end
                retire: begin
                    wb.valid <= 1'b1;
                    wb.data  <= alureg_input;
                    wb.ir    <= ir_input;
                    wb.pc    <= pc_input;
                    if (op == OP_OPERATION) begin
                        wb.we    <= 1'b1;
                        wb.waddr <= ir_input[15:11];
                    end else begin
                        wb.waddr <= '0;
                    end
                    if (mem_op)
                        align_error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wb_valid        = wb.valid;
    assign wb_data         = wb.data;
    assign wb_ir           = wb.ir;
    assign wb_pc           = wb.pc;
    assign rf_write_enable = wb.we;
    assign rf_waddr        = wb.waddr;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomised bench for mem_wb_stage against a per-instruction
// reference model of retire value, latency and sticky flags.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    localparam int          T   = 4;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic [31:0] alureg_input;
    logic [31:0] ir_input;
    logic [31:0] pc_input;
    logic [31:0] store_data_input;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [31:0] wb_ir;
    logic [31:0] wb_pc;
    logic        rf_write_enable;
    logic [4:0]  rf_waddr;
    logic        align_error;
    logic        dmem_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_align = 0;
    bit exp_to    = 0;

    mem_wb_stage #(
        .TIMEOUT_CYCLES(T),
        .ERR_DATA      (ERR)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .in_valid        (in_valid),
        .alureg_input    (alureg_input),
        .ir_input        (ir_input),
        .pc_input        (pc_input),
        .store_data_input(store_data_input),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_wdata      (dmem_wdata),
        .dmem_rdata      (dmem_rdata),
        .dmem_ready      (dmem_ready),
        .stall           (stall),
        .wb_valid        (wb_valid),
        .wb_data         (wb_data),
        .wb_ir           (wb_ir),
        .wb_pc           (wb_pc),
        .rf_write_enable (rf_write_enable),
        .rf_waddr        (rf_waddr),
        .align_error     (align_error),
        .dmem_timeout    (dmem_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("bubble_valid", 32'(wb_valid), 0);
        check("bubble_we", 32'(rf_write_enable), 0);
        @(negedge clk);
    endtask

    // Starts just after a negedge, returns just after a negedge.
    task automatic run_op(input logic [31:0] ir,
                          input logic [31:0] alu,
                          input logic [31:0] pc,
                          input logic [31:0] sd,
                          input logic [31:0] rd,
                          input int          waits);
        logic [5:0]  op;
        bit          mem, mis, acc, to, we_exp, first, fin;
        int          busy_n, stall_exp, stall_n, req_n, left;
        logic [4:0]  wa_exp;
        logic [31:0] d_exp;
        op  = ir[31:26];
        mem = (op == OP_LW) || (op == OP_SW);
        mis = (alu[1:0] != 2'b00);
        acc = mem && !mis;
        to  = acc && (waits >= T);
        busy_n    = acc ? ((waits + 1 < T) ? waits + 1 : T) : 0;
        stall_exp = acc ? busy_n + 1 : 0;
        we_exp = (op == OP_OPERATION) || (acc && op == OP_LW);
        if (op == OP_OPERATION)
            wa_exp = ir[15:11];
        else if (acc && op == OP_LW)
            wa_exp = ir[20:16];
        else
            wa_exp = 5'd0;
        d_exp = (acc && op == OP_LW) ? (to ? ERR : rd) : alu;
        if (mem && mis) exp_align = 1;
        if (to) exp_to = 1;

        in_valid         = 1'b1;
        ir_input         = ir;
        alureg_input     = alu;
        pc_input         = pc;
        store_data_input = sd;
        stall_n = 0;
        req_n   = 0;
        left    = waits;
        first   = 1;
        fin     = 0;
        for (int c = 0; c < 60 && !fin; c++) begin
            #1;
            dmem_ready = 1'b0;
            if (dmem_req) begin
                req_n++;
                if (first) begin
                    first = 0;
                    check("req_addr", dmem_addr, alu);
                    check("req_we", 32'(dmem_we),
                          32'(op == OP_SW));
                    if (op == OP_SW)
                        check("req_wdata", dmem_wdata, sd);
                end
                if (left == 0) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = rd;
                end else begin
                    left--;
                end
            end
            if (stall) stall_n++;
            @(posedge clk);
            #1;
            dmem_ready = 1'b0;
            if (wb_valid) begin
                fin = 1;
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        if (!fin) begin
            check("retire_bound", 0, 1);
        end else begin
            check("stall_cycles", stall_n, stall_exp);
            check("req_cycles", req_n, busy_n);
            check("rf_we", 32'(rf_write_enable), 32'(we_exp));
            if (!(mem && mis))
                check("wb_data", wb_data, d_exp);
            if (we_exp || op == OP_BNE || op == OP_J)
                check("rf_waddr", 32'(rf_waddr), 32'(wa_exp));
            check("wb_ir", wb_ir, ir);
            check("wb_pc", wb_pc, pc);
            check("align_err", 32'(align_error), 32'(exp_align));
            check("timeout", 32'(dmem_timeout), 32'(exp_to));
        end
    endtask

    function automatic logic [31:0] mk_ir(input logic [5:0] op,
                                          input logic [4:0] rt,
                                          input logic [4:0] rd);
        logic [31:0] r;
        r = $urandom;
        r[31:26] = op;
        r[20:16] = rt;
        r[15:11] = rd;
        return r;
    endfunction

    logic [5:0] ops [6];

    initial begin
        ops = '{OP_OPERATION, OP_LW, OP_SW, OP_BNE, OP_J, 6'h3F};
        resetn           = 1'b0;
        in_valid         = 1'b0;
        alureg_input     = '0;
        ir_input         = '0;
        pc_input         = '0;
        store_data_input = '0;
        dmem_rdata       = '0;
        dmem_ready       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_valid", 32'(wb_valid), 0);
        check("rst_req", 32'(dmem_req), 0);
        check("rst_stall", 32'(stall), 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_flags", {30'd0, align_error, dmem_timeout}, 0);
        @(negedge clk);
        resetn = 1'b1;
        idle();

        run_op(mk_ir(OP_OPERATION, 5'd0, 5'd3), 32'h10,
               32'h100, 32'h0, 32'h0, 0);
        idle();
        run_op(mk_ir(OP_LW, 5'd7, 5'd0), 32'h40,
               32'h104, 32'h0, 32'hCAFEBABE, 2);
        idle();
        run_op(mk_ir(OP_SW, 5'd9, 5'd0), 32'h44,
               32'h108, 32'h1234, 32'h0, 0);
        idle();
        run_op(mk_ir(OP_LW, 5'd5, 5'd0), 32'h42,
               32'h10C, 32'h0, 32'h0, 0);
        idle();
        run_op(mk_ir(OP_LW, 5'd6, 5'd0), 32'h80,
               32'h110, 32'h0, 32'h5555, 100);
        idle();
        run_op(mk_ir(OP_LW, 5'd8, 5'd0), 32'h84,
               32'h114, 32'h0, 32'h7777, T - 1);
        idle();

        // Abandon an access with reset while BUSY
        in_valid     = 1'b1;
        ir_input     = mk_ir(OP_LW, 5'd4, 5'd0);
        alureg_input = 32'h90;
        pc_input     = 32'h118;
        repeat (2) @(posedge clk);
        #3;
        check("busy_req", 32'(dmem_req), 1);
        resetn   = 1'b0;
        in_valid = 1'b0;
        #1;
        check("arst_req", 32'(dmem_req), 0);
        check("arst_stall", 32'(stall), 0);
        check("arst_wb_valid", 32'(wb_valid), 0);
        check("arst_flags", {30'd0, align_error, dmem_timeout}, 0);
        exp_align = 0;
        exp_to    = 0;
        @(negedge clk);
        resetn = 1'b1;
        idle();
        run_op(mk_ir(OP_OPERATION, 5'd0, 5'd12), 32'hABCD,
               32'h11C, 32'h0, 32'h0, 0);
        idle();

        for (int i = 0; i < 60; i++) begin
            logic [5:0]  op;
            logic [31:0] alu;
            op  = ops[$urandom_range(0, 5)];
            alu = $urandom;
            if ((op == OP_LW || op == OP_SW) && $urandom_range(0, 3) != 0)
                alu[1:0] = 2'b00;
            run_op(mk_ir(op, 5'($urandom), 5'($urandom)), alu,
                   $urandom, $urandom, $urandom,
                   $urandom_range(0, T + 1));
            if ($urandom_range(0, 1) == 1)
                idle();
            else
                idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
